// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, cause encoding
// and the per-stage shadow entry.
package hazard_ctrl_pkg;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LDUSE  = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_FREEZE = 2'd3
   } hz_state_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       is_load;
   } shadow_t;

   // Event counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/hz_decode.sv
// Operand/destination decode of one RV32 instruction word.
// Unused source/destination fields are returned as x0 so callers can compare blindly.
module hz_decode
   import hazard_ctrl_pkg::*;
(
   input  logic [31:0] inst,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic        rs1_used,
   output logic        rs2_used,
   output logic        is_load
);

   logic [6:0] opcode;
   logic       rd_wr;
   logic       unused_fields;

   assign opcode        = inst[6:0];
   assign unused_fields = ^{inst[31:25], inst[14:12]};

   always_comb begin
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      rd_wr    = 1'b0;
      is_load  = 1'b0;
      case (opcode)
         OP_REG: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
            rd_wr    = 1'b1;
         end
         OP_IMM, OP_JALR: begin
            rs1_used = 1'b1;
            rd_wr    = 1'b1;
         end
         OP_LOAD: begin
            rs1_used = 1'b1;
            rd_wr    = 1'b1;
            is_load  = 1'b1;
         end
         OP_STORE, OP_BRANCH: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OP_JAL, OP_LUI, OP_AUIPC: rd_wr = 1'b1;
         default: ;
      endcase
   end

   assign rs1 = rs1_used ? inst[19:15] : 5'd0;
   assign rs2 = rs2_used ? inst[24:20] : 5'd0;
   assign rd  = rd_wr    ? inst[11:7]  : 5'd0;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: picks one cause per cycle and drives the
// pipeline-register enables/flushes combinationally from it.
//
//  state  | meaning
//  RUN    | normal advance of every stage
//  LDUSE  | hold PC and IF/ID, inject one bubble into ID/EX behind a load
//  FLUSH  | taken branch in EX: PC loads target, IF/ID and ID/EX become bubbles
//  FREEZE | data memory busy: nothing moves, shadows hold
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        id_valid_i,
   input  logic [31:0] id_inst_i,
   input  logic        br_taken_i,
   input  logic        dmem_busy_i,
   output logic        pc_en_o,
   output logic        ifid_en_o,
   output logic        ifid_flush_o,
   output logic        idex_en_o,
   output logic        idex_flush_o,
   output logic        exmem_en_o,
   output logic [1:0]  state_o,
   output logic [15:0] lduse_cnt_o,
   output logic [15:0] flush_cnt_o
);

   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       id_rd;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic             id_is_load;
   logic             lduse;
   hz_state_e        cause;
   hz_state_e        state_q;
   shadow_t          ex_q;
   shadow_t          mem_q;
   shadow_t          ex_next;
   logic [CNT_W-1:0] lduse_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;
   logic             unused_mem;

   hz_decode u_decode (
      .inst     (id_inst_i),
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .rd       (id_rd),
      .rs1_used (id_rs1_used),
      .rs2_used (id_rs2_used),
      .is_load  (id_is_load)
   );

   // Decode already maps unused operands to x0, and ex_q.rd != 0 excludes x0.
   assign lduse = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) && id_valid_i &&
                  ((id_rs1_used && (id_rs1 == ex_q.rd)) ||
                   (id_rs2_used && (id_rs2 == ex_q.rd)));

   always_comb begin
      cause        = ST_RUN;
      pc_en_o      = 1'b1;
      ifid_en_o    = 1'b1;
      ifid_flush_o = 1'b0;
      idex_en_o    = 1'b1;
      idex_flush_o = 1'b0;
      exmem_en_o   = 1'b1;
      ex_next      = '0;

      if (dmem_busy_i)     cause = ST_FREEZE;
      else if (br_taken_i) cause = ST_FLUSH;
      else if (lduse)      cause = ST_LDUSE;

      case (cause)
         ST_RUN: begin
            ex_next.valid   = id_valid_i;
            ex_next.rd      = id_rd;
            ex_next.is_load = id_is_load;
         end
         ST_LDUSE: begin
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_flush_o = 1'b1;
         end
         // IF/ID stays enabled so the cleared bubble is actually captured.
         ST_FLUSH: begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
         end
         ST_FREEZE: begin
            pc_en_o    = 1'b0;
            ifid_en_o  = 1'b0;
            idex_en_o  = 1'b0;
            exmem_en_o = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_RUN;
         ex_q        <= '0;
         mem_q       <= '0;
         lduse_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= cause;
         if (cause != ST_FREEZE) begin
            mem_q <= ex_q;
            ex_q  <= ex_next;
         end
         if (cause == ST_LDUSE) lduse_cnt_q <= sat_inc(lduse_cnt_q);
         if (cause == ST_FLUSH) flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   // MEM shadow tracks the load one stage on; kept for forwarding logic, not stall decisions.
   assign unused_mem = ^mem_q;

   assign state_o     = state_q;
   assign lduse_cnt_o = lduse_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed corner sequences
// and random traffic against an instruction-level reference model.
module tb_hazard_ctrl;

   localparam logic [6:0] T_REG    = 7'b0110011;
   localparam logic [6:0] T_IMM    = 7'b0010011;
   localparam logic [6:0] T_LOAD   = 7'b0000011;
   localparam logic [6:0] T_STORE  = 7'b0100011;
   localparam logic [6:0] T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_JALR   = 7'b1100111;
   localparam logic [6:0] T_JAL    = 7'b1101111;
   localparam logic [6:0] T_LUI    = 7'b0110111;
   localparam logic [6:0] T_AUIPC  = 7'b0010111;
   localparam logic [6:0] T_SYS    = 7'b1110011;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
   localparam logic [5:0] O_RUN    = 6'b110101;
   localparam logic [5:0] O_LDUSE  = 6'b000111;
   localparam logic [5:0] O_FLUSH  = 6'b111111;
   localparam logic [5:0] O_FREEZE = 6'b000000;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        id_valid_i = 1'b0;
   logic [31:0] id_inst_i = 32'd0;
   logic        br_taken_i = 1'b0;
   logic        dmem_busy_i = 1'b0;
   logic        pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o;
   logic [1:0]  state_o;
   logic [15:0] lduse_cnt_o, flush_cnt_o;

   int n_checks = 0;
   int n_fail = 0;

   // reference model: the instruction word sitting in EX, prior cause, counters
   bit          m_ex_live;
   logic [31:0] m_ex_inst;
   int          m_state, m_lcnt, m_fcnt;

   hazard_ctrl dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .id_valid_i   (id_valid_i),
      .id_inst_i    (id_inst_i),
      .br_taken_i   (br_taken_i),
      .dmem_busy_i  (dmem_busy_i),
      .pc_en_o      (pc_en_o),
      .ifid_en_o    (ifid_en_o),
      .ifid_flush_o (ifid_flush_o),
      .idex_en_o    (idex_en_o),
      .idex_flush_o (idex_flush_o),
      .exmem_en_o   (exmem_en_o),
      .state_o      (state_o),
      .lduse_cnt_o  (lduse_cnt_o),
      .flush_cnt_o  (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        v;
      logic [31:0] inst;
      logic        br;
      logic        busy;
      logic [5:0]  outs;
      int          cause;
   } vec_t;

   vec_t tab[18];

   function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
      logic [4:0] d, a, b;
      d = 5'(rd); a = 5'(rs1); b = 5'(rs2);
      return {7'd0, b, a, 3'd0, d, op};
   endfunction

   function automatic bit reads_reg(input logic [31:0] inst, input logic [4:0] r);
      bit u1, u2;
      u1 = inst[6:0] inside {T_REG, T_IMM, T_LOAD, T_STORE, T_BRANCH, T_JALR};
      u2 = inst[6:0] inside {T_REG, T_STORE, T_BRANCH};
      if (r == 5'd0) return 1'b0;
      return (u1 && inst[19:15] == r) || (u2 && inst[24:20] == r);
   endfunction

   function automatic logic [4:0] dest(input logic [31:0] inst);
      if (inst[6:0] inside {T_REG, T_IMM, T_LOAD, T_JALR, T_JAL, T_LUI, T_AUIPC}) return inst[11:7];
      return 5'd0;
   endfunction

   function automatic int model_cause(input logic v, input logic [31:0] inst, input logic br, input logic busy);
      if (busy) return 3;
      if (br) return 2;
      if (m_ex_live && m_ex_inst[6:0] == T_LOAD && dest(m_ex_inst) != 5'd0 && v &&
          reads_reg(inst, dest(m_ex_inst))) return 1;
      return 0;
   endfunction

   function automatic logic [5:0] outs_for(input int c);
      case (c)
         0: return O_RUN;
         1: return O_LDUSE;
         2: return O_FLUSH;
         default: return O_FREEZE;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ex_live = 1'b0;
      m_ex_inst = 32'd0;
      m_state = 0;
      m_lcnt = 0;
      m_fcnt = 0;
   endtask

   // Called at posedge+1; drives one cycle, checks at negedge, updates model after the edge.
   task automatic step(input logic v, input logic [31:0] inst, input logic br, input logic busy,
                       input bit tab_en, input logic [5:0] tab_outs, input int tab_cause);
      int c;
      logic [5:0] outs;
      id_valid_i = v; id_inst_i = inst; br_taken_i = br; dmem_busy_i = busy;
      @(negedge clk_i);
      c = model_cause(v, inst, br, busy);
      outs = {pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o};
      chk("outs_vs_model", 32'(outs), 32'(outs_for(c)));
      chk("state_o", 32'(state_o), 32'(m_state));
      chk("lduse_cnt", 32'(lduse_cnt_o), 32'(m_lcnt));
      chk("flush_cnt", 32'(flush_cnt_o), 32'(m_fcnt));
      if (tab_en) chk("outs_vs_table", 32'(outs), 32'(tab_outs));
      @(posedge clk_i); #1;
      if (c != 3) begin
         m_ex_live = (c == 0) && v;
         m_ex_inst = inst;
      end
      m_state = c;
      if (c == 1 && m_lcnt < 65535) m_lcnt++;
      if (c == 2 && m_fcnt < 65535) m_fcnt++;
      if (tab_en) chk("state_vs_table", 32'(state_o), 32'(tab_cause));
   endtask

   task automatic go(input logic v, input logic [31:0] inst, input logic br, input logic busy);
      step(v, inst, br, busy, 1'b0, 6'd0, 0);
   endtask

   task automatic go_exp(input logic [31:0] inst, input logic br, input logic busy,
                         input logic [5:0] o, input int c);
      step(1'b1, inst, br, busy, 1'b1, o, c);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      id_valid_i = 1'b0; id_inst_i = 32'd0; br_taken_i = 1'b0; dmem_busy_i = 1'b0;
      @(posedge clk_i); #1;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_lduse_cnt", 32'(lduse_cnt_o), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      model_reset();
   endtask

   initial begin
      logic [31:0] lw5, add65;
      logic [6:0]  ops[10];
      lw5   = mk(T_LOAD, 5, 1, 0);
      add65 = mk(T_REG, 6, 5, 1);

      tab[0]  = '{1, lw5,                      0, 0, O_RUN,    0};
      tab[1]  = '{1, add65,                    0, 0, O_LDUSE,  1};
      tab[2]  = '{1, add65,                    0, 0, O_RUN,    0};
      tab[3]  = '{1, mk(T_LOAD, 0, 1, 0),      0, 0, O_RUN,    0};
      tab[4]  = '{1, mk(T_REG, 6, 0, 0),       0, 0, O_RUN,    0};
      tab[5]  = '{1, mk(T_LOAD, 7, 2, 0),      0, 0, O_RUN,    0};
      tab[6]  = '{1, mk(T_REG, 8, 1, 7),       1, 0, O_FLUSH,  2};
      tab[7]  = '{1, mk(T_STORE, 0, 2, 7),     0, 0, O_RUN,    0};
      tab[8]  = '{1, mk(T_LOAD, 9, 2, 0),      0, 0, O_RUN,    0};
      tab[9]  = '{1, mk(T_STORE, 0, 2, 9),     0, 0, O_LDUSE,  1};
      tab[10] = '{1, mk(T_BRANCH, 0, 9, 3),    0, 0, O_RUN,    0};
      tab[11] = '{1, mk(T_LOAD, 10, 1, 0),     0, 0, O_RUN,    0};
      tab[12] = '{0, mk(T_REG, 11, 10, 10),    0, 0, O_RUN,    0};
      tab[13] = '{1, mk(T_LOAD, 10, 1, 0),     0, 0, O_RUN,    0};
      tab[14] = '{1, mk(T_LUI, 12, 10, 10),    0, 0, O_RUN,    0};
      tab[15] = '{1, mk(T_LOAD, 13, 1, 0),     0, 1, O_FREEZE, 3};
      tab[16] = '{1, mk(T_LOAD, 13, 1, 0),     0, 0, O_RUN,    0};
      tab[17] = '{1, mk(T_JALR, 1, 13, 0),     0, 0, O_LDUSE,  1};

      do_reset();
      foreach (tab[i])
         step(tab[i].v, tab[i].inst, tab[i].br, tab[i].busy, 1'b1, tab[i].outs, tab[i].cause);
      chk("tab_lduse_total", 32'(lduse_cnt_o), 32'd3);
      chk("tab_flush_total", 32'(flush_cnt_o), 32'd1);

      // single load-use bubble then RUN
      do_reset();
      go_exp(lw5, 0, 0, O_RUN, 0);
      go_exp(add65, 0, 0, O_LDUSE, 1);
      go_exp(add65, 0, 0, O_RUN, 0);
      chk("lduse_once_cnt", 32'(lduse_cnt_o), 32'd1);

      // x0 load never stalls
      do_reset();
      go_exp(mk(T_LOAD, 0, 1, 0), 0, 0, O_RUN, 0);
      go_exp(mk(T_REG, 6, 0, 0), 0, 0, O_RUN, 0);

      // branch beats load-use
      do_reset();
      go_exp(lw5, 0, 0, O_RUN, 0);
      go_exp(add65, 1, 0, O_FLUSH, 2);
      chk("flush_over_lduse_lcnt", 32'(lduse_cnt_o), 32'd0);
      chk("flush_over_lduse_fcnt", 32'(flush_cnt_o), 32'd1);

      // three frozen cycles with branch pending, then FLUSH
      do_reset();
      go_exp(lw5, 0, 0, O_RUN, 0);
      for (int k = 0; k < 3; k++) go_exp(add65, 1, 1, O_FREEZE, 3);
      go_exp(add65, 1, 0, O_FLUSH, 2);

      // shadows hold through FREEZE: load still in EX afterwards
      do_reset();
      go_exp(lw5, 0, 0, O_RUN, 0);
      for (int k = 0; k < 2; k++) go_exp(add65, 0, 1, O_FREEZE, 3);
      go_exp(add65, 0, 0, O_LDUSE, 1);

      // saturation of the load-use counter
      do_reset();
      force dut.lduse_cnt_q = 16'hFFFE;
      #1;
      release dut.lduse_cnt_q;
      m_lcnt = 16'hFFFE;
      for (int k = 0; k < 3; k++) begin
         go(1'b1, lw5, 1'b0, 1'b0);
         go_exp(add65, 0, 0, O_LDUSE, 1);
         chk("lduse_sat", 32'(lduse_cnt_o), 32'hFFFF);
      end

      // reset dropped in the middle of a load-use stall
      do_reset();
      go(1'b1, lw5, 1'b0, 1'b0);
      go(1'b1, add65, 1'b0, 1'b0);
      go(1'b1, lw5, 1'b0, 1'b0);
      id_valid_i = 1'b1; id_inst_i = add65; br_taken_i = 1'b0; dmem_busy_i = 1'b0;
      @(negedge clk_i);
      chk("midstall_outs", 32'({pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o}),
          32'(O_LDUSE));
      #1 rst_ni = 1'b0;
      #1;
      chk("midstall_rst_state", 32'(state_o), 32'd0);
      chk("midstall_rst_lcnt", 32'(lduse_cnt_o), 32'd0);
      chk("midstall_rst_outs", 32'({pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o, exmem_en_o}),
          32'(O_RUN));
      @(posedge clk_i); #1;
      chk("midstall_rst_state_held", 32'(state_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      model_reset();
      go_exp(add65, 0, 0, O_RUN, 0);

      // random traffic against the model
      ops[0] = T_REG; ops[1] = T_IMM; ops[2] = T_LOAD; ops[3] = T_STORE; ops[4] = T_BRANCH;
      ops[5] = T_JALR; ops[6] = T_JAL; ops[7] = T_LUI; ops[8] = T_AUIPC; ops[9] = T_SYS;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         logic [31:0] ri;
         ri = $urandom;
         ri[6:0]   = ($urandom_range(0, 2) == 0) ? T_LOAD : ops[$urandom_range(0, 9)];
         ri[11:7]  = 5'($urandom_range(0, 3));
         ri[19:15] = 5'($urandom_range(0, 3));
         ri[24:20] = 5'($urandom_range(0, 3));
         go(1'($urandom_range(0, 7) != 0), ri, 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 5) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports follow.
- clk_i, input, 1: rising-edge clock.
- rst_ni, input, 1: asynchronous active-low reset.
- id_valid_i, input, 1: IF/ID register holds a live instruction.
- id_inst_i, input, 32: instruction in ID.
- br_taken_i, input, 1: branch or jump resolved taken in EX this cycle.
- dmem_busy_i, input, 1: data memory not done; whole pipeline must hold.
- pc_en_o, output, 1: PC register update enable.
- ifid_en_o, output, 1: IF/ID register load enable.
- ifid_flush_o, output, 1: IF/ID register cleared to bubble.
- idex_en_o, output, 1: ID/EX register load enable.
- idex_flush_o, output, 1: ID/EX register loads a bubble.
- exmem_en_o, output, 1: EX/MEM and MEM/WB load enable.
- state_o, output, 2: registered cause of the previous cycle (RUN, LDUSE, FLUSH, FREEZE).
- lduse_cnt_o, output, 16: saturating count of load-use stall cycles.
- flush_cnt_o, output, 16: saturating count of flush cycles.

Function
REQ-002 SHALL decode from id_inst_i[6:0]:
- rs1 used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
- rs2 used for opcodes 0110011, 0100011, 1100011.
- rd written for opcodes 0110011, 0010011, 0000011, 1100111, 1101111, 0110111, 0010111.
- is_load for opcode 0000011.
- Register x0 never creates a dependency.
REQ-003 SHALL keep registered shadow entries {valid, rd[4:0], is_load} for the EX stage and the MEM stage.
REQ-004 Load-use is true when EX.valid, EX.is_load, EX.rd!=0, id_valid_i, and EX.rd matches a used rs1 or rs2 of the ID instruction.
REQ-005 Causes SHALL be evaluated combinationally in this priority order: FREEZE (dmem_busy_i), then FLUSH (br_taken_i), then LDUSE, then RUN.
REQ-006 RUN: pc_en_o, ifid_en_o, idex_en_o and exmem_en_o are 1; both flush outputs are 0.
REQ-007 LDUSE:
- pc_en_o=0, ifid_en_o=0, idex_en_o=1, idex_flush_o=1, exmem_en_o=1.
- Exactly one bubble is inserted; the next cycle re-evaluates with the load in MEM and results in RUN.
REQ-008 FLUSH:
- pc_en_o=1 (PC loads the target), ifid_flush_o=1, idex_flush_o=1, idex_en_o=1, exmem_en_o=1.
- LDUSE is suppressed in the same cycle.
REQ-009 FREEZE:
- All enable outputs are 0 and both flush outputs are 0.
- Shadow entries hold.
- A br_taken_i held during FREEZE produces FLUSH in the first cycle after dmem_busy_i falls.
REQ-010 Shadow update on each non-FREEZE edge:
- MEM entry <= EX entry.
- EX entry <= {id_valid_i, rd-or-0, is_load} in RUN.
- EX entry <= bubble (valid=0) in LDUSE or FLUSH.
REQ-011 state_o SHALL register the cause evaluated in the previous cycle, with encoding RUN=0, LDUSE=1, FLUSH=2, FREEZE=3.
REQ-012 lduse_cnt_o SHALL increment by 1 per LDUSE cycle and flush_cnt_o by 1 per FLUSH cycle; both saturate at 16'hFFFF and never wrap.
REQ-013 All enable and flush outputs SHALL be purely combinational from the inputs and the shadow registers, with zero-cycle latency.

Reset
REQ-014 While rst_ni=0:
- Shadow entries are cleared (valid=0, rd=0, is_load=0).
- state_o=RUN; both counters are 0.
REQ-015 Combinational outputs during reset SHALL follow REQ-005..008 using the cleared shadow state.
REQ-016 Reset asserted mid-stall SHALL abandon the stall immediately; no pending flush or bubble survives reset.

Structure
REQ-017 The shared package SHALL hold the opcode constants, the 2-bit state enum and the shadow-entry struct {valid, rd, is_load}.
REQ-018 The operand/rd decode SHALL be a sub-module hz_decode (combinational) so the decode stage can reuse it.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- EX=lw x5, ID=add x6,x5,x1 -> one cycle: pc_en_o=0, idex_flush_o=1, state_o=LDUSE next cycle; then RUN; lduse_cnt_o=1.
- EX=lw x0, ID=add x6,x0,x0 -> no stall; all enables 1.
- br_taken_i=1 while a load-use condition is present -> ifid_flush_o=1, idex_flush_o=1, pc_en_o=1; lduse_cnt_o unchanged; flush_cnt_o=1.
- dmem_busy_i=1 for 3 cycles with br_taken_i=1 -> all enables 0 for 3 cycles; FLUSH in cycle 4.
- Force lduse_cnt_o to 16'hFFFE, then apply 3 load-use stalls -> counter ends at 16'hFFFF.
- rst_ni dropped during LDUSE -> shadow entries cleared, state_o=RUN, counters 0; first cycle after release is RUN.
